// File: rtl/sel_rr_arbiter8_pkg.sv
// Shared constants and state encoding for the round-robin select arbiter.
package sel_rr_arbiter8_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/sel3to8.sv
// 3-to-8 binary-to-one-hot decoder shared with the path selector.
module sel3to8 (
  input  logic [2:0] sel,
  output logic [7:0] dec
);

  assign dec = 8'b0000_0001 << sel;

endmodule

// File: rtl/sel_rr_arbiter8_pick.sv
// Rotating priority encoder: first asserted request at or after ptr, wrapping 7->0.
module rr_pick8
  import sel_rr_arbiter8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sel_rr_arbiter8.sv
// Round-robin arbiter with hold-time limit and break-before-make gap,
// driving the select code and one-hot grant for the shared 3-to-8 path.
module sel_rr_arbiter8
  import sel_rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [SEL_W-1:0]   select,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic               busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         gap_cnt;
  logic [SEL_W-1:0]   ptr;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;
  logic               start;
  logic               stay;
  logic               gact_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [NUM_REQ-1:0] dec_nxt;
  logic [NUM_REQ-1:0] grant_nxt;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-cycle ownership: a new winner from IDLE, or the current owner continuing.
  assign start    = (state == ST_IDLE) && en && pick_found;
  assign stay     = (state == ST_GRANT) && req[select] && (cnt < HOLD_LAST);
  assign gact_nxt = start || stay;
  assign sel_nxt  = start ? pick_idx : select;

  sel3to8 u_dec (
    .sel (sel_nxt),
    .dec (dec_nxt)
  );

  assign grant_nxt = dec_nxt & {NUM_REQ{gact_nxt}};

  always_ff @(posedge clk1) begin
    if (rst) begin
      state       <= ST_IDLE;
      select      <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      busy        <= 1'b0;
      cnt         <= '0;
      gap_cnt     <= '0;
      ptr         <= '0;
    end else begin
      grant       <= grant_nxt;
      grant_valid <= gact_nxt;
      select      <= sel_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (stay) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            // Release and timeout share this exit; the served index drops to lowest priority.
            ptr     <= select + SEL_W'(1);
            cnt     <= '0;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sel_rr_arbiter8.sv
// Directed bench for sel_rr_arbiter8 with MAX_HOLD=4, GAP_CYCLES=1 and a per-cycle scoreboard.
module tb_sel_rr_arbiter8;

  logic       clk1 = 1'b0;
  logic       rst  = 1'b1;
  logic       en   = 1'b0;
  logic [7:0] req  = '0;
  logic [2:0] select;
  logic [7:0] grant;
  logic       grant_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] g;
    logic [2:0] s;
    logic       b;
  } exp_t;

  exp_t sb[$];

  sel_rr_arbiter8 #(.MAX_HOLD(4), .GAP_CYCLES(1)) dut (
    .clk1        (clk1),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .select      (select),
    .grant       (grant),
    .grant_valid (grant_valid),
    .busy        (busy)
  );

  always #5 clk1 = ~clk1;

  // Drive one cycle of inputs, record what the DUT must show after the edge, then compare.
  task automatic step(input logic r, input logic e, input logic [7:0] q,
                      input logic [7:0] eg, input logic [2:0] es, input logic eb,
                      input string tag);
    exp_t x;
    @(negedge clk1);
    rst = r;
    en  = e;
    req = q;
    x.g = eg;
    x.s = es;
    x.b = eb;
    sb.push_back(x);
    @(posedge clk1);
    #1;
    x = sb.pop_front();
    checks++;
    assert (grant === x.g) else begin
      errors++;
      $error("FAIL %s grant: got %h expected %h", tag, grant, x.g);
    end
    checks++;
    assert (select === x.s) else begin
      errors++;
      $error("FAIL %s select: got %0d expected %0d", tag, select, x.s);
    end
    checks++;
    assert (busy === x.b) else begin
      errors++;
      $error("FAIL %s busy: got %b expected %b", tag, busy, x.b);
    end
    checks++;
    assert (grant_valid === (x.g != 8'h00)) else begin
      errors++;
      $error("FAIL %s grant_valid: got %b expected %b", tag, grant_valid, (x.g != 8'h00));
    end
  endtask

  // Continuous request: four grant cycles, one gap cycle, one idle cycle.
  task automatic hold_full(input logic [7:0] q, input logic [2:0] idx, input string tag);
    logic [7:0] oh;
    oh = 8'h01 << idx;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, q, oh, idx, 1'b1, tag);
    step(1'b0, 1'b1, q, 8'h00, idx, 1'b1, {tag, "_gap"});
    step(1'b0, 1'b1, q, 8'h00, idx, 1'b0, {tag, "_idle"});
  endtask

  initial begin
    // Reset with all requests pending
    step(1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, "rst0");
    step(1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, "rst1");
    step(1'b0, 1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, "first_grant");
    step(1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b1, "rel0_gap");
    step(1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "rel0_idle");

    // Single requester 5 for three cycles
    step(1'b0, 1'b1, 8'h20, 8'h20, 3'd5, 1'b1, "r5_c1");
    step(1'b0, 1'b1, 8'h20, 8'h20, 3'd5, 1'b1, "r5_c2");
    step(1'b0, 1'b1, 8'h20, 8'h20, 3'd5, 1'b1, "r5_c3");
    step(1'b0, 1'b1, 8'h00, 8'h00, 3'd5, 1'b1, "r5_gap");
    step(1'b0, 1'b1, 8'h00, 8'h00, 3'd5, 1'b0, "r5_idle");

    // ptr must now be 6: requester 6 beats requester 0
    step(1'b0, 1'b1, 8'h41, 8'h40, 3'd6, 1'b1, "ptr6");
    step(1'b0, 1'b1, 8'h00, 8'h00, 3'd6, 1'b1, "ptr6_gap");
    step(1'b0, 1'b1, 8'h00, 8'h00, 3'd6, 1'b0, "ptr6_idle");

    // Timeout: requester 2 holds for exactly 4 cycles, then is re-granted
    hold_full(8'h04, 3'd2, "tmo");
    step(1'b0, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1, "tmo_regrant");
    step(1'b0, 1'b1, 8'h00, 8'h00, 3'd2, 1'b1, "tmo_gap");
    step(1'b0, 1'b1, 8'h00, 8'h00, 3'd2, 1'b0, "tmo_idle");

    // Round-robin over requesters 0, 2, 7 starting from ptr 3
    hold_full(8'h85, 3'd7, "rr7a");
    hold_full(8'h85, 3'd0, "rr0");
    hold_full(8'h85, 3'd2, "rr2");
    hold_full(8'h85, 3'd7, "rr7b");

    // Enable: blocked while low, in-flight grant completes when dropped
    step(1'b0, 1'b0, 8'h10, 8'h00, 3'd7, 1'b0, "en_off0");
    step(1'b0, 1'b0, 8'h10, 8'h00, 3'd7, 1'b0, "en_off1");
    step(1'b0, 1'b1, 8'h10, 8'h10, 3'd4, 1'b1, "en_grant");
    step(1'b0, 1'b0, 8'h10, 8'h10, 3'd4, 1'b1, "en_drop_hold");
    step(1'b0, 1'b0, 8'h00, 8'h00, 3'd4, 1'b1, "en_gap");
    step(1'b0, 1'b0, 8'h10, 8'h00, 3'd4, 1'b0, "en_idle");
    step(1'b0, 1'b0, 8'h10, 8'h00, 3'd4, 1'b0, "en_still_off");
    step(1'b0, 1'b1, 8'h10, 8'h10, 3'd4, 1'b1, "en_regrant");
    step(1'b0, 1'b1, 8'h00, 8'h00, 3'd4, 1'b1, "en_rel_gap");
    step(1'b0, 1'b1, 8'h00, 8'h00, 3'd4, 1'b0, "en_rel_idle");

    // Reset mid-grant: no gap afterwards, search restarts from ptr 0
    step(1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, "mid_grant");
    step(1'b1, 1'b1, 8'h08, 8'h00, 3'd0, 1'b0, "mid_rst");
    step(1'b0, 1'b1, 8'h28, 8'h08, 3'd3, 1'b1, "post_rst_grant");
    step(1'b0, 1'b1, 8'h00, 8'h00, 3'd3, 1'b1, "post_rst_gap");
    step(1'b0, 1'b1, 8'h00, 8'h00, 3'd3, 1'b0, "post_rst_idle");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
